rvfpm_xif_issue_buffer: RTL and testbench
=========================================

RVFPM_XIF_ISSUE_BUFFER -- requirements
Module: rvfpm_xif_issue_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32: operand width.
REQ-003 SHALL have parameter X_ID_WIDTH, default 4: XIF instruction id width.
REQ-004 SHALL have parameter X_NUM_RS, default 3: source operands per instruction.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 ck  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 issue_valid  input  1  XIF issue request valid.
REQ-009 issue_ready  output  1  buffer can take the issue request.
REQ-010 issue_accept  input  1  predecoder accepts the instruction as FP.
REQ-011 issue_instr  input  32  instruction word.
REQ-012 issue_id  input  X_ID_WIDTH  instruction id.
REQ-013 issue_rs  input  X_NUM_RS*XLEN  operands; operand i at bits [i*XLEN +: XLEN].
REQ-014 issue_rs_valid  input  X_NUM_RS  per-operand valid.
REQ-015 use_rs  input  X_NUM_RS  per-operand "used" from predecoder.
REQ-016 commit_valid  input  1  XIF commit strobe.
REQ-017 commit_id  input  X_ID_WIDTH  id being committed or killed.
REQ-018 commit_kill  input  1  1 = kill, 0 = commit.
REQ-019 exec_valid  output  1  head entry committed and offered to FPU core.
REQ-020 exec_ready  input  1  FPU core takes head entry.
REQ-021 exec_instr / exec_id / exec_rs  output  32 / X_ID_WIDTH / X_NUM_RS*XLEN  head entry contents.
REQ-022 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-023 issue_ready SHALL be combinational: !full AND, for every i, (!use_rs[i] OR issue_rs_valid[i]); no pop-to-push bypass when full.
REQ-024 Push SHALL occur when issue_valid & issue_ready & issue_accept; the entry stores instr, id, rs and starts in state PEND.
REQ-025 Each entry SHALL be in state PEND, COMM or KILL; free slots carry no state.
REQ-026 commit_valid SHALL set the matching PEND entry (id equal) to KILL if commit_kill, else COMM; no match, or match on COMM/KILL, is ignored.
REQ-027 A commit whose id equals a same-cycle push SHALL apply to the pushed entry.
REQ-028 exec_valid SHALL equal (head state == COMM); exec_* SHALL drive head contents; pop on exec_valid & exec_ready.
REQ-029 A KILL head SHALL be popped on the next edge without asserting exec_valid, one entry per cycle.
REQ-030 A PEND head SHALL block all younger entries (strict in-order).
REQ-031 Once exec_valid is asserted, it and exec_* SHALL stay stable until exec_ready.
REQ-032 Minimum latency: push and commit at edge N -> exec_valid high after edge N.
REQ-033 Read/write pointers SHALL be $clog2(DEPTH)+1 bits, wrapping naturally; full = MSBs differ and LSBs equal.
REQ-034 Simultaneous push and pop SHALL keep count unchanged.
REQ-035 count SHALL never exceed DEPTH; issue_ready SHALL be 0 at count == DEPTH.

Reset
REQ-036 rst_n low SHALL immediately clear pointers, count and all entry states; exec_valid = 0, count = 0, issue_ready follows REQ-023 with empty buffer.
REQ-037 Reset mid-operation SHALL discard all entries, including one being popped; no exec handshake completes in that cycle.

Configuration
REQ-038 Macro RVFPM_IBUF_FLUSH_EN defined: adds input flush (1 bit); flush high at an edge turns every PEND entry into KILL; COMM entries are unaffected; a same-cycle push enters as KILL.
REQ-039 Macro RVFPM_IBUF_FLUSH_EN undefined: no flush port; behaviour as REQ-023..REQ-035 only.

Verification
REQ-040 DEPTH=4, push ids 1,2,3,4 with no commits -> count=4, issue_ready=0, exec_valid=0.
REQ-041 Push id 5 and commit id 5 in the same cycle with exec_ready=1 -> exec_valid=1 the next cycle with exec_id=5; popped; count returns to 0.
REQ-042 Push ids 1,2; kill 1, commit 2 -> id 1 dropped silently; exec_id=2 presented one cycle later.
REQ-043 Push ids 1,2; commit 2 only -> exec_valid stays 0 until commit 1, then ids 1 and 2 issue in order.
REQ-044 use_rs=3'b101, issue_rs_valid=3'b001 -> issue_ready=0; set issue_rs_valid=3'b101 -> issue_ready=1.
REQ-045 Push 3 entries, pull rst_n low between edges -> count=0 and exec_valid=0 immediately; with RVFPM_IBUF_FLUSH_EN, flush with 2 PEND entries plus 1 COMM entry -> only the COMM entry is issued.

Source files
------------

// File: rtl/rvfpm_xif_issue_buffer.sv
// In-order issue buffer between the XIF issue/commit interfaces and the FP core.
// Optional flush input enabled by defining RVFPM_IBUF_FLUSH_EN.
module rvfpm_xif_issue_buffer #(
  parameter int DEPTH      = 4,
  parameter int XLEN       = 32,
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 3,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                       ck,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       issue_accept,
  input  logic [31:0]                issue_instr,
  input  logic [X_ID_WIDTH-1:0]      issue_id,
  input  logic [X_NUM_RS*XLEN-1:0]   issue_rs,
  input  logic [X_NUM_RS-1:0]        issue_rs_valid,
  input  logic [X_NUM_RS-1:0]        use_rs,
  input  logic                       commit_valid,
  input  logic [X_ID_WIDTH-1:0]      commit_id,
  input  logic                       commit_kill,
`ifdef RVFPM_IBUF_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       exec_valid,
  input  logic                       exec_ready,
  output logic [31:0]                exec_instr,
  output logic [X_ID_WIDTH-1:0]      exec_id,
  output logic [X_NUM_RS*XLEN-1:0]   exec_rs,
  output logic [AW:0]                count
);

  typedef enum logic [1:0] {ST_PEND = 2'd0, ST_COMM = 2'd1, ST_KILL = 2'd2} st_e;

  st_e                      st_q    [DEPTH];
  st_e                      st_d    [DEPTH];
  logic [31:0]              instr_q [DEPTH];
  logic [X_ID_WIDTH-1:0]    id_q    [DEPTH];
  logic [X_NUM_RS*XLEN-1:0] rs_q    [DEPTH];

  logic [AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0]  head, tail;
  logic [DEPTH-1:0] occ;
  logic full, rs_ok, push, pop, head_comm, head_kill, flush_w;
  st_e  push_st;

`ifdef RVFPM_IBUF_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign head  = rptr_q[AW-1:0];
  assign tail  = wptr_q[AW-1:0];
  assign count = wptr_q - rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Every operand the predecoder marks as used must already be valid.
  assign rs_ok       = &(~use_rs | issue_rs_valid);
  assign issue_ready = !full && rs_ok;
  assign push        = issue_valid && issue_ready && issue_accept;

  assign head_comm = (count != '0) && (st_q[head] == ST_COMM);
  assign head_kill = (count != '0) && (st_q[head] == ST_KILL);
  assign pop       = (head_comm && exec_ready) || head_kill;

  assign exec_valid = head_comm;
  assign exec_instr = instr_q[head];
  assign exec_id    = id_q[head];
  assign exec_rs    = rs_q[head];

  // Slot is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_occ
    logic [AW-1:0] off;
    assign off    = AW'(g) - head;
    assign occ[g] = {1'b0, off} < count;
  end

  always_comb begin
    push_st = ST_PEND;
    if (flush_w)
      push_st = ST_KILL;
    else if (commit_valid && (commit_id == issue_id))
      push_st = commit_kill ? ST_KILL : ST_COMM;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i] = st_q[i];
      if (occ[i] && (st_q[i] == ST_PEND)) begin
        if (flush_w)
          st_d[i] = ST_KILL;
        else if (commit_valid && (commit_id == id_q[i]))
          st_d[i] = commit_kill ? ST_KILL : ST_COMM;
      end
      if (push && (tail == AW'(i)))
        st_d[i] = push_st;
    end
  end

  assign wptr_d = wptr_q + (AW+1)'(push);
  assign rptr_d = rptr_q + (AW+1)'(pop);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) st_q[i] <= ST_PEND;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      for (int i = 0; i < DEPTH; i++) st_q[i] <= st_d[i];
    end
  end

  // Payload needs no reset: occupancy and state gate every use of it.
  always_ff @(posedge ck) begin
    if (push) begin
      instr_q[tail] <= issue_instr;
      id_q[tail]    <= issue_id;
      rs_q[tail]    <= issue_rs;
    end
  end

endmodule

// File: tb/tb_rvfpm_xif_issue_buffer.sv
// Randomized + directed bench for rvfpm_xif_issue_buffer against a queue model.
module tb_rvfpm_xif_issue_buffer;
  localparam int DEPTH = 4, XLEN = 32, IDW = 4, NRS = 3, RSW = NRS * XLEN;
  localparam int AW = $clog2(DEPTH);
  localparam int SP = 0, SC = 1, SK = 2;

  logic ck = 1'b0, rst_n = 1'b0;
  logic issue_valid, issue_ready, issue_accept;
  logic [31:0] issue_instr;
  logic [IDW-1:0] issue_id;
  logic [RSW-1:0] issue_rs;
  logic [NRS-1:0] issue_rs_valid, use_rs;
  logic commit_valid, commit_kill, flush;
  logic [IDW-1:0] commit_id;
  logic exec_valid, exec_ready;
  logic [31:0] exec_instr;
  logic [IDW-1:0] exec_id;
  logic [RSW-1:0] exec_rs;
  logic [AW:0] count;

  rvfpm_xif_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .X_ID_WIDTH(IDW), .X_NUM_RS(NRS)) dut (
    .ck(ck), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_accept(issue_accept),
    .issue_instr(issue_instr), .issue_id(issue_id), .issue_rs(issue_rs),
    .issue_rs_valid(issue_rs_valid), .use_rs(use_rs),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
`ifdef RVFPM_IBUF_FLUSH_EN
    .flush(flush),
`endif
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_instr(exec_instr),
    .exec_id(exec_id), .exec_rs(exec_rs), .count(count)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [31:0]    instr;
    logic [IDW-1:0] id;
    logic [RSW-1:0] rs;
    int             st;
  } ent_t;

  ent_t q[$];
  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_q(input logic [IDW-1:0] id);
    foreach (q[i]) if (q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  // Model outputs follow directly from the queue of in-flight instructions.
  task automatic compare_all();
    logic mready, mvalid;
    mready = (q.size() < DEPTH) && (&(~use_rs | issue_rs_valid));
    mvalid = (q.size() > 0) && (q[0].st == SC);
    chk("count", 128'(count), 128'(q.size()));
    chk("issue_ready", 128'(issue_ready), 128'(mready));
    chk("exec_valid", 128'(exec_valid), 128'(mvalid));
    if (mvalid) begin
      chk("exec_id", 128'(exec_id), 128'(q[0].id));
      chk("exec_instr", 128'(exec_instr), 128'(q[0].instr));
      chk("exec_rs", 128'(exec_rs), 128'(q[0].rs));
    end
  endtask

  task automatic model_step();
    bit   push;
    ent_t e;
    push = issue_valid && issue_accept && (q.size() < DEPTH) && (&(~use_rs | issue_rs_valid));
    if (q.size() > 0 && (q[0].st == SK || (q[0].st == SC && exec_ready)))
      void'(q.pop_front());
    foreach (q[i]) begin
      if (q[i].st == SP) begin
        if (flush) q[i].st = SK;
        else if (commit_valid && commit_id == q[i].id) q[i].st = commit_kill ? SK : SC;
      end
    end
    if (push) begin
      e.instr = issue_instr; e.id = issue_id; e.rs = issue_rs;
      if (flush) e.st = SK;
      else if (commit_valid && commit_id == issue_id) e.st = commit_kill ? SK : SC;
      else e.st = SP;
      q.push_back(e);
    end
  endtask

  // Inputs are held from posedge+1; check at negedge, then advance model with the edge.
  task automatic cycle();
    @(negedge ck);
    compare_all();
    @(posedge ck);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic set_idle();
    issue_valid = 0; issue_accept = 1; issue_instr = '0; issue_id = '0; issue_rs = '0;
    issue_rs_valid = '0; use_rs = '0; commit_valid = 0; commit_id = '0; commit_kill = 0;
    exec_ready = 0; flush = 0;
  endtask

  task automatic set_push(input logic [IDW-1:0] id);
    set_idle();
    issue_valid = 1; issue_id = id; issue_instr = $urandom;
    issue_rs = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    int nseen;
    logic [IDW-1:0] sid, cand;
    set_idle();
    #2;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_exec_valid", 128'(exec_valid), 128'(0));
    chk("rst_issue_ready", 128'(issue_ready), 128'(1));
    cycle(); cycle();
    rst_n = 1;

    // Fill to DEPTH with no commits.
    for (int k = 1; k <= 4; k++) begin set_push(IDW'(k)); cycle(); end
    set_idle(); #1;
    chk("fill_count", 128'(count), 128'(4));
    chk("fill_ready", 128'(issue_ready), 128'(0));
    chk("fill_exec_valid", 128'(exec_valid), 128'(0));
    for (int k = 1; k <= 4; k++) begin
      set_idle(); commit_valid = 1; commit_id = IDW'(k); commit_kill = 1; cycle();
    end
    set_idle(); cycle(); cycle(); #1;
    chk("drain_count", 128'(count), 128'(0));

    // Push and commit in the same cycle.
    set_push(4'd5); commit_valid = 1; commit_id = 4'd5; exec_ready = 1; cycle();
    set_idle(); exec_ready = 1; #1;
    chk("same_exec_valid", 128'(exec_valid), 128'(1));
    chk("same_exec_id", 128'(exec_id), 128'(5));
    chk("same_count", 128'(count), 128'(1));
    cycle(); #1;
    chk("same_pop_count", 128'(count), 128'(0));
    chk("same_pop_valid", 128'(exec_valid), 128'(0));

    // Kill older, commit younger.
    set_push(4'd1); cycle();
    set_push(4'd2); cycle();
    set_idle(); commit_valid = 1; commit_id = 4'd1; commit_kill = 1; cycle();
    set_idle(); commit_valid = 1; commit_id = 4'd2; cycle();
    set_idle(); #1;
    chk("kill_exec_valid", 128'(exec_valid), 128'(1));
    chk("kill_exec_id", 128'(exec_id), 128'(2));
    chk("kill_count", 128'(count), 128'(1));
    exec_ready = 1; cycle(); #1;
    chk("kill_drain", 128'(count), 128'(0));

    // Pending head blocks a committed younger entry.
    set_push(4'd1); cycle();
    set_push(4'd2); cycle();
    set_idle(); commit_valid = 1; commit_id = 4'd2; cycle();
    for (int k = 0; k < 2; k++) begin
      set_idle(); exec_ready = 1; #1;
      chk("block_exec_valid", 128'(exec_valid), 128'(0));
      cycle();
    end
    set_idle(); commit_valid = 1; commit_id = 4'd1; cycle();
    set_idle(); #1;
    chk("order_first_valid", 128'(exec_valid), 128'(1));
    chk("order_first_id", 128'(exec_id), 128'(1));
    exec_ready = 1; cycle(); #1;
    chk("order_second_valid", 128'(exec_valid), 128'(1));
    chk("order_second_id", 128'(exec_id), 128'(2));
    cycle(); #1;
    chk("order_drain", 128'(count), 128'(0));

    // Operand readiness gating.
    set_idle(); use_rs = 3'b101; issue_rs_valid = 3'b001; #1;
    chk("rs_not_ready", 128'(issue_ready), 128'(0));
    issue_rs_valid = 3'b101; #1;
    chk("rs_ready", 128'(issue_ready), 128'(1));
    cycle();

    // Asynchronous reset with a pop pending.
    set_push(4'd1); commit_valid = 1; commit_id = 4'd1; cycle();
    set_push(4'd2); cycle();
    set_push(4'd3); cycle();
    set_idle(); exec_ready = 1; #1;
    rst_n = 0; q.delete(); #1;
    chk("arst_count", 128'(count), 128'(0));
    chk("arst_exec_valid", 128'(exec_valid), 128'(0));
    cycle();
    rst_n = 1; #1;
    chk("arst_after_count", 128'(count), 128'(0));
    cycle();

`ifdef RVFPM_IBUF_FLUSH_EN
    // Flush with two pending and one committed entry.
    set_push(4'd1); cycle();
    set_push(4'd2); cycle();
    set_push(4'd3); commit_valid = 1; commit_id = 4'd3; cycle();
    set_idle(); flush = 1; exec_ready = 1; cycle();
    set_idle(); exec_ready = 1;
    nseen = 0; sid = '0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (exec_valid) begin nseen++; sid = exec_id; end
      cycle();
    end
    chk("flush_issued_n", 128'(nseen), 128'(1));
    chk("flush_issued_id", 128'(sid), 128'(3));
`endif

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      cand = $urandom;
      for (int t = 0; t < 100; t++) begin
        if (!in_q(cand)) break;
        cand = $urandom;
      end
      set_push(cand);
      issue_valid    = ($urandom_range(0, 3) != 0);
      issue_accept   = ($urandom_range(0, 7) != 0);
      use_rs         = NRS'($urandom);
      issue_rs_valid = ($urandom_range(0, 3) == 0) ? NRS'($urandom) : (use_rs | NRS'($urandom));
      commit_valid   = ($urandom_range(0, 2) != 0);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        commit_id = q[$urandom_range(0, q.size() - 1)].id;
      else if ($urandom_range(0, 1) == 1)
        commit_id = issue_id;
      else
        commit_id = $urandom;
      commit_kill = ($urandom_range(0, 3) == 0);
      exec_ready  = ($urandom_range(0, 2) != 0);
`ifdef RVFPM_IBUF_FLUSH_EN
      flush = ($urandom_range(0, 49) == 0);
`endif
      if ($urandom_range(0, 399) == 0) begin
        #2; rst_n = 0; q.delete(); #1;
        chk("rand_arst_count", 128'(count), 128'(0));
        chk("rand_arst_valid", 128'(exec_valid), 128'(0));
        @(posedge ck); #1;
        rst_n = 1;
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
